width_change_24to16: RTL and testbench

Reverse-direction width converter that turns a stream of 3-pixel-byte words (QUAN_BITS*3) back into 2-byte words (QUAN_BITS*2). It is the read-back counterpart of the 16->24 packer, placed where 24-bit pixel/feature data returns to 16-bit RAM/DMA paths. Byte order is little-endian on both sides, so it exactly inverts the packer: in {b2,b1,b0},{b5,b4,b3} -> out {b1,b0},{b3,b2},{b5,b4}. Sustains full rate: 2 inputs / 3 outputs per 3 cycles.

---
 rtl/width_change_24to16_pkg.sv | 14 +
 rtl/width_change_24to16.sv | 111 +++++++++++
 tb/tb_width_change_24to16.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/width_change_24to16_pkg.sv
// Shared hyper-parameters for the 24->16 byte-lane width converter.
package width_change_24to16_pkg;

   localparam int QUAN_BITS = 8;
   localparam int IN_LANES  = 3;
   localparam int OUT_LANES = 2;
   localparam int BUF_LANES = 6;

   // Lanes consumed by one output word: a single byte only as the padded tail.
   function automatic logic [2:0] emit_width(input logic [2:0] cnt);
      emit_width = (cnt >= 3'd2) ? 3'd2 : 3'd1;
   endfunction

endpackage

// File: rtl/width_change_24to16.sv
// Repacks little-endian 3-byte input words into 2-byte output words through a
// 6-lane byte buffer; the final word of a frame is padded when it holds one byte.
module width_change_24to16 #(
   parameter int QUAN_BITS = width_change_24to16_pkg::QUAN_BITS
) (
   input  logic                     s_clk,
   input  logic                     s_rst,
   input  logic [QUAN_BITS*3-1:0]   bytes_in,
   input  logic                     bytes_in_valid,
   input  logic                     bytes_in_last,
   output logic                     o_bytes_in_ready,
   output logic [QUAN_BITS*2-1:0]   o_bytes_out,
   output logic                     o_bytes_out_valid,
   output logic [1:0]               o_bytes_out_keep,
   output logic                     o_bytes_out_last,
   input  logic                     bytes_out_ready
);

   import width_change_24to16_pkg::*;

   logic [QUAN_BITS-1:0] lane_q    [BUF_LANES];
   logic [QUAN_BITS-1:0] lane_d    [BUF_LANES];
   logic [QUAN_BITS-1:0] shift_s   [BUF_LANES];
   logic [QUAN_BITS-1:0] in_lane_s [IN_LANES];
   logic [2:0]           cnt_q, cnt_d;
   logic                 pend_last_q, pend_last_d;
   logic                 run_q, run_d;
   logic                 valid_s, last_s;
   logic                 accept_s, emit_s;
   logic [2:0]           ew_s, base_s, src_s;

   // Output decode from buffer state only; run_q keeps ready low on the first cycle after reset.
   always_comb begin
      valid_s = (cnt_q >= 3'd2) || (pend_last_q && (cnt_q == 3'd1));
      last_s  = pend_last_q && (cnt_q <= 3'd2) && valid_s;
      o_bytes_in_ready  = run_q && (cnt_q <= 3'd3) && !pend_last_q;
      o_bytes_out_valid = valid_s;
      o_bytes_out_last  = last_s;
      if (!valid_s) begin
         o_bytes_out_keep = 2'b00;
      end else if (cnt_q >= 3'd2) begin
         o_bytes_out_keep = 2'b11;
      end else begin
         o_bytes_out_keep = 2'b01;
      end
      if (cnt_q == 3'd1) begin
         o_bytes_out = {{QUAN_BITS{1'b0}}, lane_q[0]};
      end else begin
         o_bytes_out = {lane_q[1], lane_q[0]};
      end
   end

   // Handshakes, buffer shift-and-insert, and count/frame bookkeeping.
   always_comb begin
      accept_s = bytes_in_valid && o_bytes_in_ready;
      emit_s   = valid_s && bytes_out_ready;
      ew_s     = emit_s ? emit_width(cnt_q) : 3'd0;
      base_s   = cnt_q - ew_s;
      src_s    = 3'd0;
      for (int j = 0; j < IN_LANES; j++) begin
         in_lane_s[j] = bytes_in[j*QUAN_BITS +: QUAN_BITS];
      end
      for (int i = 0; i < BUF_LANES; i++) begin
         src_s = 3'(i) + ew_s;
         if (src_s < 3'(BUF_LANES)) begin
            shift_s[i] = lane_q[src_s];
         end else begin
            shift_s[i] = '0;
         end
      end
      // New lanes land directly above whatever survives this cycle's emit.
      for (int i = 0; i < BUF_LANES; i++) begin
         if (accept_s && (3'(i) >= base_s) && (3'(i) < (base_s + 3'd3))) begin
            lane_d[i] = in_lane_s[2'(3'(i) - base_s)];
         end else begin
            lane_d[i] = shift_s[i];
         end
      end
      cnt_d       = cnt_q + (accept_s ? 3'd3 : 3'd0) - ew_s;
      pend_last_d = pend_last_q;
      run_d       = 1'b1;
      if (emit_s && last_s) begin
         pend_last_d = 1'b0;
         cnt_d       = 3'd0;
      end else if (accept_s && bytes_in_last) begin
         pend_last_d = 1'b1;
      end else begin
         pend_last_d = pend_last_q;
      end
   end

   // State registers with synchronous reset; a partial frame is simply dropped.
   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         cnt_q       <= 3'd0;
         pend_last_q <= 1'b0;
         run_q       <= 1'b0;
         for (int i = 0; i < BUF_LANES; i++) begin
            lane_q[i] <= '0;
         end
      end else begin
         cnt_q       <= cnt_d;
         pend_last_q <= pend_last_d;
         run_q       <= run_d;
         for (int i = 0; i < BUF_LANES; i++) begin
            lane_q[i] <= lane_d[i];
         end
      end
   end

endmodule

// File: tb/tb_width_change_24to16.sv
// Self-checking bench: a byte-queue model of the stream predicts every output cycle.
module tb_width_change_24to16;

   logic        s_clk = 1'b0;
   logic        s_rst;
   logic [23:0] bytes_in;
   logic        bytes_in_valid, bytes_in_last;
   logic        o_bytes_in_ready;
   logic [15:0] o_bytes_out;
   logic        o_bytes_out_valid;
   logic [1:0]  o_bytes_out_keep;
   logic        o_bytes_out_last;
   logic        bytes_out_ready;

   always #5 s_clk = ~s_clk;

   width_change_24to16 #(.QUAN_BITS(8)) dut (
      .s_clk(s_clk), .s_rst(s_rst),
      .bytes_in(bytes_in), .bytes_in_valid(bytes_in_valid), .bytes_in_last(bytes_in_last),
      .o_bytes_in_ready(o_bytes_in_ready),
      .o_bytes_out(o_bytes_out), .o_bytes_out_valid(o_bytes_out_valid),
      .o_bytes_out_keep(o_bytes_out_keep), .o_bytes_out_last(o_bytes_out_last),
      .bytes_out_ready(bytes_out_ready)
   );

   int vec_cnt = 0;
   int miss_cnt = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int emit_cnt = 0;
   logic [7:0]  mq[$];
   bit          mf[$];
   logic [18:0] out_log[$];
   bit          rst_seen = 1'b0;
   bit          rand_done = 1'b0;
   bit          ev, er, el, hl;
   logic [15:0] ed;
   logic [1:0]  ek;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: queue of buffered bytes, each flagged if it is its frame's final byte.
   always @(negedge s_clk) begin
      cyc++;
      if (s_rst) begin
         mq.delete();
         mf.delete();
         rst_seen = 1'b1;
      end else begin
         hl = 1'b0;
         foreach (mf[i]) if (mf[i]) hl = 1'b1;
         ev = (mq.size() >= 2) || ((mq.size() == 1) && mf[0]);
         er = !rst_seen && (mq.size() <= 3) && !hl;
         chk("in_ready", {31'd0, o_bytes_in_ready}, {31'd0, er});
         chk("out_valid", {31'd0, o_bytes_out_valid}, {31'd0, ev});
         if (ev) begin
            if (mq.size() >= 2) begin
               ed = {mq[1], mq[0]};
               ek = 2'b11;
               el = mf[1];
            end else begin
               ed = {8'h00, mq[0]};
               ek = 2'b01;
               el = 1'b1;
            end
            chk("out_data", {16'd0, o_bytes_out}, {16'd0, ed});
            chk("out_keep", {30'd0, o_bytes_out_keep}, {30'd0, ek});
            chk("out_last", {31'd0, o_bytes_out_last}, {31'd0, el});
            if (o_bytes_out_valid && bytes_out_ready) begin
               out_log.push_back({o_bytes_out_last, o_bytes_out_keep, o_bytes_out});
               emit_cnt++;
               if (ek == 2'b11) begin
                  void'(mq.pop_front()); void'(mf.pop_front());
               end
               void'(mq.pop_front()); void'(mf.pop_front());
            end
         end else begin
            chk("idle_keep", {30'd0, o_bytes_out_keep}, 32'd0);
            chk("idle_last", {31'd0, o_bytes_out_last}, 32'd0);
         end
         if (bytes_in_valid && o_bytes_in_ready) begin
            acc_cnt++;
            mq.push_back(bytes_in[7:0]);   mf.push_back(1'b0);
            mq.push_back(bytes_in[15:8]);  mf.push_back(1'b0);
            mq.push_back(bytes_in[23:16]); mf.push_back(bytes_in_last);
         end
         rst_seen = 1'b0;
      end
   end

   task automatic send(input logic [23:0] d, input bit l);
      bit ok;
      ok = 1'b0;
      bytes_in = d; bytes_in_last = l; bytes_in_valid = 1'b1;
      for (int t = 0; t < 300 && !ok; t++) begin
         @(negedge s_clk);
         if (o_bytes_in_ready) ok = 1'b1;
      end
      if (ok) begin
         @(posedge s_clk);
         #1;
      end else begin
         chk("send_accept", {31'd0, ok}, 32'd1);
      end
      bytes_in_valid = 1'b0; bytes_in_last = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 600 && mq.size() != 0; t++) @(negedge s_clk);
      chk("drain_empty", mq.size(), 32'd0);
      @(posedge s_clk);
      #1;
   endtask

   task automatic log_chk(input string nm, input int idx, input logic [18:0] exp);
      if (idx < out_log.size()) chk(nm, {13'd0, out_log[idx]}, {13'd0, exp});
      else chk({nm, "_present"}, out_log.size(), idx + 1);
   endtask

   int a0, a1, e0, nlast, lasts_sent;
   logic [15:0] held;

   initial begin
      s_rst = 1'b1; bytes_in = 24'd0; bytes_in_valid = 1'b0; bytes_in_last = 1'b0;
      bytes_out_ready = 1'b1;
      repeat (3) @(posedge s_clk);
      #1 s_rst = 1'b0;
      @(negedge s_clk);
      chk("rst_ready", {31'd0, o_bytes_in_ready}, 32'd0);
      chk("rst_valid", {31'd0, o_bytes_out_valid}, 32'd0);
      chk("rst_out", {16'd0, o_bytes_out}, 32'd0);
      @(posedge s_clk); #1;

      // Basic pair, last on the second word.
      out_log.delete();
      send(24'h030201, 1'b0);
      send(24'h060504, 1'b1);
      drain();
      chk("t1_count", out_log.size(), 32'd3);
      log_chk("t1_w0", 0, {1'b0, 2'b11, 16'h0201});
      log_chk("t1_w1", 1, {1'b0, 2'b11, 16'h0403});
      log_chk("t1_w2", 2, {1'b1, 2'b11, 16'h0605});
      @(negedge s_clk);
      chk("t1_idle_valid", {31'd0, o_bytes_out_valid}, 32'd0);
      chk("t1_idle_ready", {31'd0, o_bytes_in_ready}, 32'd1);
      @(posedge s_clk); #1;

      // Single word frame: padded tail.
      out_log.delete();
      send(24'h0C0B0A, 1'b1);
      drain();
      chk("t2_count", out_log.size(), 32'd2);
      log_chk("t2_w0", 0, {1'b0, 2'b11, 16'h0B0A});
      log_chk("t2_w1", 1, {1'b1, 2'b01, 16'h000C});

      // Full-rate streaming of 60 words.
      out_log.delete();
      e0 = emit_cnt;
      for (int w = 0; w < 60; w++) begin
         send({8'(3*w+2), 8'(3*w+1), 8'(3*w)}, (w == 59));
         if (w == 0) a0 = cyc;
         if (w == 59) a1 = cyc;
      end
      drain();
      chk("t3_accept_span", a1 - a0, 32'd88);
      chk("t3_emits", emit_cnt - e0, 32'd90);
      log_chk("t3_first", 0, {1'b0, 2'b11, 16'h0100});
      log_chk("t3_final", 89, {1'b1, 2'b11, 16'hB3B2});

      // Downstream stall mid-stream.
      fork
         for (int w = 0; w < 12; w++) send({8'(w + 8'h40), 8'(w + 8'h20), 8'(w)}, (w == 11));
         begin
            repeat (4) @(posedge s_clk);
            #1 bytes_out_ready = 1'b0;
            @(negedge s_clk);
            held = o_bytes_out;
            repeat (5) @(posedge s_clk);
            @(negedge s_clk);
            chk("t4_ready_low", {31'd0, o_bytes_in_ready}, 32'd0);
            chk("t4_held", {16'd0, o_bytes_out}, {16'd0, held});
            @(posedge s_clk);
            #1 bytes_out_ready = 1'b1;
         end
      join
      drain();

      // Reset with a pending last and 4 buffered bytes.
      bytes_out_ready = 1'b0;
      send(24'h0A0908, 1'b0);
      send(24'h0D0C0B, 1'b1);
      bytes_out_ready = 1'b1;
      @(posedge s_clk); #1 bytes_out_ready = 1'b0;
      @(negedge s_clk);
      chk("t5_model_cnt", mq.size(), 32'd4);
      chk("t5_pend_ready", {31'd0, o_bytes_in_ready}, 32'd0);
      @(posedge s_clk); #1 s_rst = 1'b1;
      @(posedge s_clk); #1 s_rst = 1'b0;
      @(negedge s_clk);
      chk("t5_ready", {31'd0, o_bytes_in_ready}, 32'd0);
      chk("t5_valid", {31'd0, o_bytes_out_valid}, 32'd0);
      chk("t5_keep", {30'd0, o_bytes_out_keep}, 32'd0);
      chk("t5_last", {31'd0, o_bytes_out_last}, 32'd0);
      chk("t5_out", {16'd0, o_bytes_out}, 32'd0);
      bytes_out_ready = 1'b1;
      out_log.delete();
      send(24'h030201, 1'b0);
      send(24'h060504, 1'b1);
      drain();
      log_chk("t5_first", 0, {1'b0, 2'b11, 16'h0201});

      // Random valid/ready traffic over 1000 words and many frames.
      out_log.delete();
      lasts_sent = 0;
      fork
         begin
            for (int w = 0; w < 1000; w++) begin
               bit lst;
               repeat ($urandom_range(0, 2)) @(posedge s_clk);
               #1;
               lst = ($urandom_range(0, 7) == 0) || (w == 999);
               if (lst) lasts_sent++;
               send(24'($urandom), lst);
            end
            rand_done = 1'b1;
         end
         while (!rand_done) begin
            @(posedge s_clk);
            #1 bytes_out_ready = ($urandom_range(0, 3) != 0);
         end
      join
      bytes_out_ready = 1'b1;
      drain();
      nlast = 0;
      foreach (out_log[i]) if (out_log[i][18]) nlast++;
      chk("t6_frames", nlast, lasts_sent);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
